div_unit: RTL
=============

# div_unit

Multicycle signed divider for the MIPS datapath, directly downstream of the control unit. The control unit raises `DivCtrl` to request A/B, and the block runs a WIDTH-iteration restoring division. It writes the quotient to `LO` and the remainder to `HI`, then raises `DivOut`, or it raises `divZero` when B is zero. `HI` and `LO` feed the `MemToReg` mux for MFHI/MFLO.

## Interface
- `WIDTH`, default 32: operand, quotient and remainder width.

- `clk`  in  1: the single clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-low; clears all state immediately.
- `DivCtrl`  in  1: level request from the control unit; high = divide, low = release or abort.
- `A`  in  WIDTH: dividend (signed, two's complement), sampled at start.
- `B`  in  WIDTH: divisor (signed), sampled at start.
- `DivOut`  out  1: registered; high while results are valid and the request is still held.
- `divZero`  out  1: registered; high while a divide-by-zero request is held.
- `HI`  out  WIDTH: registered remainder.
- `LO`  out  WIDTH: registered quotient.

## Operation
- **States:** IDLE, RUN, FIX, DONE, ZERO.
- **Reset values:** state=IDLE, count=0, `HI`=0, `LO`=0, `DivOut`=0, `divZero`=0.
- **IDLE, `DivCtrl`=1, `B`=0:** `divZero`←1, go to ZERO. `HI`/`LO` unchanged.
- **IDLE, `DivCtrl`=1, `B`≠0:** latch sign(A), sign(B), |A| into the quotient shift register, |B| into the divisor register. Clear the partial remainder, count←0, go to RUN.
- **RUN, one iteration per cycle:**
  - Shift {rem, quo} left by 1.
  - If rem ≥ divisor (unsigned, WIDTH+1-bit compare), rem←rem−divisor and quo[0]←1.
  - When count=WIDTH−1, go to FIX; otherwise count←count+1.
- **FIX (sign correction):**
  - `LO`←quo, negated if sign(A)≠sign(B). Quotient truncates toward zero.
  - `HI`←rem, negated if sign(A)=1. Remainder takes the sign of the dividend.
  - `DivOut`←1, go to DONE.
- **DONE:** hold `DivOut`=1 until `DivCtrl`=0, then `DivOut`←0 and go to IDLE.
- **ZERO:** hold `divZero`=1 until `DivCtrl`=0, then `divZero`←0 and go to IDLE.
- **Abort:** `DivCtrl`=0 in RUN or FIX sends the block to IDLE on that edge, with `HI`/`LO` keeping their previous values.
- **Arithmetic:** absolute values are computed in WIDTH+1 bits, so the magnitude of −2^(WIDTH−1) is representable. Results are truncated to WIDTH bits.
  - Overflow case −2^(WIDTH−1) / −1 gives `LO`=0x80000000 (WIDTH=32), `HI`=0. No flag is raised.
- **Operand stability:** `A`/`B` changes after the start edge are ignored.
- `HI`/`LO` change only in FIX (and on reset).

## Timing
- **Start:** edge 0 is the first rising edge with IDLE and `DivCtrl`=1.
- **Latency:** RUN iterations occur on edges 1..WIDTH. FIX is on edge WIDTH+1 (edge 33 for WIDTH=32). `HI`, `LO` and `DivOut` are valid after edge WIDTH+1.
- **Divide-by-zero:** `divZero` is high after edge 0, i.e. 1-cycle latency.
- **Release:** `DivOut`/`divZero` fall on the first edge sampling `DivCtrl`=0. The next request is accepted no earlier than the following edge.
- **Back-to-back requests:** `DivCtrl` must drop for at least one edge; a held `DivCtrl` never retriggers.
- **Reset:** asserting `reset` at any point, including mid-RUN, forces the reset values without waiting for a clock edge. Operation resumes on the first edge after deassertion.

## Test plan
- A=7, B=2, `DivCtrl` held → after edge 33: `LO`=3, `HI`=1, `DivOut`=1; drop `DivCtrl` → `DivOut`=0 next edge, state IDLE.
- A=−7 (0xFFFFFFF9), B=2 → `LO`=0xFFFFFFFD (−3), `HI`=0xFFFFFFFF (−1). A=7, B=−2 → `LO`=0xFFFFFFFD, `HI`=1. A=−7, B=−2 → `LO`=3, `HI`=0xFFFFFFFF.
- A=0x80000000, B=0xFFFFFFFF → `LO`=0x80000000, `HI`=0. A=0x80000000, B=1 → `LO`=0x80000000, `HI`=0.
- Preload `HI`=1/`LO`=3, then A=5, B=0 → `divZero`=1 after 1 edge, `HI`/`LO` still 1/3, `DivOut`=0; drop `DivCtrl` → `divZero`=0.
- Start A=100, B=7; drop `DivCtrl` at edge 10 → IDLE, `HI`/`LO` unchanged, no `DivOut`. Restart → `LO`=14, `HI`=2.
- Start A=100, B=7; pulse `reset` low mid-RUN between edges → all outputs 0 immediately, state IDLE. A fresh request afterwards completes normally.

Source files
------------

// File: rtl/div_unit.sv
// Multicycle signed restoring divider for the MIPS datapath.
// LO receives the quotient (truncated toward zero) and HI the remainder (sign of dividend).
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    DivCtrl,
    input  logic signed [WIDTH-1:0] A,
    input  logic signed [WIDTH-1:0] B,
    output logic                    DivOut,
    output logic                    divZero,
    output logic        [WIDTH-1:0] HI,
    output logic        [WIDTH-1:0] LO
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RUN  = 3'd1,
        FIX  = 3'd2,
        DONE = 3'd3,
        ZERO = 3'd4
    } state_t;

    state_t            state;
    logic [CW-1:0]     count;
    logic              sign_a;
    logic              sign_b;
    logic [WIDTH-1:0]  quo;
    logic [WIDTH-1:0]  rem;
    logic [WIDTH:0]    dvs;
    logic [WIDTH:0]    rem_sh;
    logic              take;
    logic              start;

    // Magnitude in WIDTH+1 bits so that -2^(WIDTH-1) stays representable.
    function automatic logic [WIDTH:0] mag(input logic signed [WIDTH-1:0] v);
        logic signed [WIDTH:0] ext;
        ext = {v[WIDTH-1], v};
        return v[WIDTH-1] ? -ext : ext;
    endfunction

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign start = (state == IDLE) && DivCtrl && (B != '0);

    always_comb begin
        rem_sh = {rem, quo[WIDTH-1]};
        take   = (rem_sh >= dvs);
    end

    // Iteration datapath: operands are captured once at start and then only shifted.
    always_ff @(posedge clk) begin
        if (start) begin
            sign_a <= A[WIDTH-1];
            sign_b <= B[WIDTH-1];
            quo    <= WIDTH'(mag(A));
            dvs    <= mag(B);
            rem    <= '0;
        end else if (state == RUN) begin
            quo <= {quo[WIDTH-2:0], take};
            rem <= take ? WIDTH'(rem_sh - dvs) : rem_sh[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= '0;
            HI      <= '0;
            LO      <= '0;
            DivOut  <= 1'b0;
            divZero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (DivCtrl) begin
                        if (B == '0) begin
                            divZero <= 1'b1;
                            state   <= ZERO;
                        end else begin
                            count <= '0;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (!DivCtrl) begin
                        state <= IDLE;
                    end else if (count == LAST) begin
                        state <= FIX;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                FIX: begin
                    if (!DivCtrl) begin
                        state <= IDLE;
                    end else begin
                        LO     <= neg_if(quo, sign_a ^ sign_b);
                        HI     <= neg_if(rem, sign_a);
                        DivOut <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (!DivCtrl) begin
                        DivOut <= 1'b0;
                        state  <= IDLE;
                    end
                end
                ZERO: begin
                    if (!DivCtrl) begin
                        divZero <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
